// File: rtl/dmem_dma_arbiter.sv
// Shares one single-port data memory between the CPU and a burst-read DMA engine.
// The CPU wins by default; a pending DMA read is forced through after MAX_WAIT denied cycles.
module dmem_dma_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_wren,
  input  logic [11:0] cpu_addr,
  input  logic [31:0] cpu_data,
  output logic [31:0] cpu_q,
  output logic        cpu_stall,
  input  logic        dma_start,
  input  logic [11:0] dma_base,
  input  logic [4:0]  dma_len,
  output logic        dma_busy,
  output logic [31:0] dma_q,
  output logic        dma_valid,
  output logic        dma_done,
  output logic        ram_wEn,
  output logic [11:0] ram_addr,
  output logic [31:0] ram_dataIn,
  input  logic [31:0] ram_dataOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  state_t      state;
  logic [11:0] ptr;
  logic [4:0]  rem;
  logic [3:0]  wait_cnt;
  logic        dma_gnt;
  logic        vld_p1;
  logic [31:0] word_p1;

  assign dma_gnt    = (state == BURST) && (!cpu_req || (wait_cnt == WAIT_LIM));
  assign cpu_stall  = cpu_req && dma_gnt;
  assign ram_addr   = dma_gnt ? ptr : cpu_addr;
  assign ram_wEn    = !dma_gnt && cpu_req && cpu_wren;
  assign ram_dataIn = cpu_data;
  assign cpu_q      = ram_dataOut;

  // RAM data for a grant arrives the cycle after it; present it live then, hold it afterwards
  assign dma_valid = vld_p1;
  assign dma_q     = vld_p1 ? ram_dataOut : word_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      rem      <= '0;
      wait_cnt <= '0;
      vld_p1   <= 1'b0;
      word_p1  <= '0;
      dma_done <= 1'b0;
      dma_busy <= 1'b0;
    end else begin
      vld_p1   <= dma_gnt;
      dma_done <= 1'b0;
      if (vld_p1) begin
        word_p1 <= ram_dataOut;
      end
      case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dma_start && (dma_len != 5'd0)) begin
            ptr      <= dma_base;
            rem      <= dma_len;
            dma_busy <= 1'b1;
            state    <= BURST;
          end
        end
        BURST: begin
          if (dma_gnt) begin
            ptr      <= ptr + 12'd1;
            rem      <= rem - 5'd1;
            wait_cnt <= '0;
            if (rem == 5'd1) begin
              dma_done <= 1'b1;
              state    <= DRAIN;
            end
          end else if (cpu_req && (wait_cnt != WAIT_LIM)) begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DRAIN: begin
          wait_cnt <= '0;
          dma_busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          wait_cnt <= '0;
          dma_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/dmem_dma_arbiter.md
DMEM_DMA_ARBITER -- requirements
Module: dmem_dma_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 4: max consecutive cycles a pending DMA read may be denied by the CPU; legal range 1..15.
REQ-002 clock  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  CPU requests a data-memory access this cycle.
REQ-005 cpu_wren  input  1  CPU access is a write.
REQ-006 cpu_addr  input  12  CPU word address.
REQ-007 cpu_data  input  32  CPU write data.
REQ-008 cpu_q  output  32  CPU read data; combinational pass-through of ram_dataOut.
REQ-009 cpu_stall  output  1  CPU access denied this cycle; CPU must hold its request.
REQ-010 dma_start  input  1  single-cycle pulse starting a burst read.
REQ-011 dma_base  input  12  burst start address, sampled with dma_start.
REQ-012 dma_len  input  5  burst word count, 1..16, sampled with dma_start.
REQ-013 dma_busy  output  1  high from the cycle after accepted dma_start through the DRAIN cycle inclusive.
REQ-014 dma_q  output  32  DMA read data, registered.
REQ-015 dma_valid  output  1  dma_q holds a new word this cycle.
REQ-016 dma_done  output  1  one-cycle pulse, burst complete.
REQ-017 ram_wEn, ram_addr[11:0], ram_dataIn[31:0]  output  RAM control; ram_dataOut[31:0]  input, valid one cycle after address.

Function
REQ-018 States IDLE, BURST, DRAIN; state is 2-bit registered.
REQ-019 IDLE: dma_start with dma_len != 0 latches ptr=dma_base, rem=dma_len, next state BURST; dma_len == 0 is ignored, no state change.
REQ-020 dma_start while in BURST or DRAIN is ignored.
REQ-021 In BURST, dma_gnt = !cpu_req || (wait_cnt == MAX_WAIT); outside BURST dma_gnt = 0.
REQ-022 When dma_gnt: ram_addr = ptr, ram_wEn = 0, ptr increments mod 4096 (4095 -> 0), rem decrements; if rem reaches 0, next state DRAIN.
REQ-023 When !dma_gnt: ram_addr = cpu_addr, ram_dataIn = cpu_data, ram_wEn = cpu_req && cpu_wren.
REQ-024 cpu_stall = cpu_req && dma_gnt; never high outside BURST.
REQ-025 wait_cnt (4-bit): in BURST increments when cpu_req && !dma_gnt, saturating at MAX_WAIT; clears on dma_gnt and in IDLE/DRAIN.
REQ-026 Under continuous cpu_req, DMA receives exactly one slot per MAX_WAIT+1 cycles.
REQ-027 dma_valid asserted in the cycle after each DMA grant; dma_q registered from ram_dataOut on that cycle, held otherwise.
REQ-028 DRAIN lasts exactly one cycle: asserts final dma_valid and dma_done together, next state IDLE; CPU has full access.
REQ-029 A new dma_start is accepted in the first IDLE cycle after DRAIN.
REQ-030 Total words delivered per burst equals dma_len exactly; order is ascending address with wrap.

Reset
REQ-031 Reset asynchronously forces state IDLE, ptr=0, rem=0, wait_cnt=0, dma_q=0, dma_valid=0, dma_done=0, dma_busy=0.
REQ-032 During reset cpu_stall=0, ram_wEn follows cpu_req && cpu_wren, ram_addr=cpu_addr.
REQ-033 Reset mid-burst aborts the burst; no dma_done and no further dma_valid are produced.

Verification
REQ-034 cpu_req=0, dma_start base=0x010 len=4, RAM[0x010..0x013]=1,2,3,4 -> dma_valid 4 consecutive cycles with dma_q 1,2,3,4, dma_done on 4th, dma_busy 5 cycles total (4 BURST + DRAIN).
REQ-035 cpu_req=1 continuous, MAX_WAIT=4, len=2 -> cpu_stall high exactly on cycles 5 and 10 of BURST; dma_done after 11 BURST+DRAIN cycles; CPU writes on unstalled cycles land in RAM.
REQ-036 base=0xFFE len=4 -> reads addresses 0xFFE, 0xFFF, 0x000, 0x001 in order.
REQ-037 dma_len=0 start, then dma_start during BURST with different base -> both ignored; original burst completes unchanged.
REQ-038 Assert reset after 2 of 8 words -> outputs zero immediately (asynchronously), no dma_done; following dma_start len=1 completes normally.
REQ-039 CPU write 0xDEADBEEF to 0x020 in cycle DMA is idle, then DMA len=1 base=0x020 -> dma_q=0xDEADBEEF.
